// File: rtl/serial_rx_pkg.sv
// Shared state encoding, default sizes and a width helper for the buffered serial receiver.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DATA   = 2'b01,
    PARITY = 2'b10,
    STOP   = 2'b11
  } rx_state_t;

  localparam int DEFAULT_PKT_W = 55;

  // Ceiling log2, used for pointer and counter widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/rx_pkt_fifo.sv
// First-word-fall-through packet buffer with an occupancy counter.
// A pop while empty is ignored; a push while full only lands if a pop happens in the same cycle.
module rx_pkt_fifo
  import serial_rx_pkg::*;
#(
  parameter int PKT_W = DEFAULT_PKT_W,
  parameter int DEPTH = 4
) (
  input  logic             Clk_S,
  input  logic             Rst,
  input  logic             push,
  input  logic             pop,
  input  logic [PKT_W-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [PKT_W-1:0] rdata
);
  localparam int PTR_W = clog2(DEPTH);

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge Clk_S) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk_S) begin
    if (Rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_rx_buffered.sv
// Framed serial receiver (start, PKT_W data bits MSB-first, stop) feeding a FWFT packet buffer.
// Define SERIAL_RX_PARITY_EN to expect an even-parity bit between the last data bit and the stop bit.
module serial_rx_buffered
  import serial_rx_pkg::*;
#(
  parameter int PKT_W = DEFAULT_PKT_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             Clk_S,
  input  logic             Rst,
  input  logic             S_data,
  input  logic             RX_Ready,
  output logic             RX_Data_Valid,
  output logic [PKT_W-1:0] RX_Data,
  output logic             RX_Frame_Err,
  output logic             RX_Overflow,
  output logic [CNT_W-1:0] RX_Drop_Cnt
);
  localparam int              BC_W     = clog2(PKT_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(PKT_W - 1);

  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [PKT_W-1:0] shift_reg;
  logic [BC_W-1:0]  bit_cnt;
  logic             wait_low;
  logic             par_err;
  logic             commit;
  logic             frame_bad;
  logic             overflow;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  always_ff @(posedge Clk_S) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // wait_low blocks a line still stuck high after a bad stop bit from posing as a new start bit.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    frame_bad = 1'b0;
    case (state)
      IDLE: begin
        if (S_data && !wait_low) state_nxt = DATA;
      end
      DATA: begin
        if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
      PARITY: state_nxt = STOP;
      STOP: begin
        state_nxt = IDLE;
        if (S_data || par_err) frame_bad = 1'b1;
        else                   commit    = 1'b1;
      end
    endcase
  end

  assign pop      = !empty && RX_Ready;
  assign overflow = commit && full && !pop;
  assign push     = commit && !overflow;

  always_ff @(posedge Clk_S) begin
    if (Rst) begin
      shift_reg    <= '0;
      bit_cnt      <= '0;
      wait_low     <= 1'b0;
      RX_Frame_Err <= 1'b0;
      RX_Overflow  <= 1'b0;
      RX_Drop_Cnt  <= '0;
    end else begin
      RX_Frame_Err <= frame_bad;
      RX_Overflow  <= overflow;
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (state == DATA) begin
        shift_reg <= {shift_reg[PKT_W-2:0], S_data};
        bit_cnt   <= bit_cnt + 1'b1;
      end
      if (state == STOP && S_data)       wait_low <= 1'b1;
      else if (state == IDLE && !S_data) wait_low <= 1'b0;
      if ((frame_bad || overflow) && (RX_Drop_Cnt != {CNT_W{1'b1}}))
        RX_Drop_Cnt <= RX_Drop_Cnt + 1'b1;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  // Even parity: the parity bit must equal the XOR of the data bits.
  always_ff @(posedge Clk_S) begin
    if (Rst || state == IDLE) par_err <= 1'b0;
    else if (state == PARITY) par_err <= (S_data != ^shift_reg);
  end
`else
  assign par_err = 1'b0;
`endif

  rx_pkt_fifo #(
    .PKT_W (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk_S (Clk_S),
    .Rst   (Rst),
    .push  (push),
    .pop   (pop),
    .wdata (shift_reg),
    .full  (full),
    .empty (empty),
    .rdata (RX_Data)
  );

  assign RX_Data_Valid = !empty;

endmodule

// File: tb/tb_serial_rx_buffered.sv
// Self-checking bench for serial_rx_buffered: table-driven frames, hand-written corner cases
// and randomized frames checked against a queue-based reference model.
module tb_serial_rx_buffered;
  localparam int PKT_W = 55;
  localparam int DEPTH = 4;

  logic             Clk_S = 1'b0;
  logic             Rst;
  logic             S_data;
  logic             RX_Ready;
  logic             RX_Data_Valid;
  logic [PKT_W-1:0] RX_Data;
  logic             RX_Frame_Err;
  logic             RX_Overflow;
  logic [7:0]       RX_Drop_Cnt;
  logic             sat_valid;
  logic [PKT_W-1:0] sat_data;
  logic             sat_fe;
  logic             sat_ov;
  logic [1:0]       sat_drop;

  always #5 Clk_S = ~Clk_S;

  serial_rx_buffered #(.PKT_W(PKT_W), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .Clk_S(Clk_S), .Rst(Rst), .S_data(S_data), .RX_Ready(RX_Ready),
    .RX_Data_Valid(RX_Data_Valid), .RX_Data(RX_Data), .RX_Frame_Err(RX_Frame_Err),
    .RX_Overflow(RX_Overflow), .RX_Drop_Cnt(RX_Drop_Cnt)
  );

  serial_rx_buffered #(.PKT_W(PKT_W), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .Clk_S(Clk_S), .Rst(Rst), .S_data(S_data), .RX_Ready(RX_Ready),
    .RX_Data_Valid(sat_valid), .RX_Data(sat_data), .RX_Frame_Err(sat_fe),
    .RX_Overflow(sat_ov), .RX_Drop_Cnt(sat_drop)
  );

  typedef struct {
    logic [PKT_W-1:0] data;
    int               bad_stop;
    int               bad_par;
    int               stop_rdy;
    int               exp_valid;
    logic [PKT_W-1:0] exp_head;
    int               exp_fe;
    int               exp_ov;
    int               exp_drop;
    int               exp_sat;
  } vec_t;

  int               checks = 0;
  int               failures = 0;
  logic [PKT_W-1:0] model_q[$];
  logic             exp_fe;
  logic             exp_ov;
  int               drop_m;
  logic [PKT_W-1:0] cur_frame;
  logic             samp_valid;
  logic [PKT_W-1:0] samp_data;
  logic             samp_fe;
  logic             samp_ov;
  logic [7:0]       samp_drop;
  vec_t             tbl[9];
  logic [PKT_W-1:0] drain_exp[5];

  function automatic int sat_at(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic logic pick(input int m);
    if (m == 2) return logic'($urandom_range(0, 1));
    return (m == 1);
  endfunction

  function automatic logic [PKT_W-1:0] model_head();
    if (model_q.size() == 0) return '0;
    return model_q[0];
  endfunction

  function automatic vec_t mk(input logic [PKT_W-1:0] d, input int bs, input int bp, input int sr,
                              input int v, input logic [PKT_W-1:0] h, input int fe, input int ov,
                              input int dr, input int sat);
    vec_t r;
    r.data = d; r.bad_stop = bs; r.bad_par = bp; r.stop_rdy = sr; r.exp_valid = v;
    r.exp_head = h; r.exp_fe = fe; r.exp_ov = ov; r.exp_drop = dr; r.exp_sat = sat;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample and check outputs at the negedge, drive new inputs, then advance the
  // model to what the next posedge must produce. ev: 0 none, 1 good stop bit, 2 bad frame.
  task automatic applyStimulus(input logic sd, input logic rdy, input int ev);
    logic pop_m;
    @(negedge Clk_S);
    samp_valid = RX_Data_Valid;
    samp_data  = RX_Data;
    samp_fe    = RX_Frame_Err;
    samp_ov    = RX_Overflow;
    samp_drop  = RX_Drop_Cnt;
    checkOutput("valid", 64'(samp_valid), 64'(model_q.size() != 0));
    checkOutput("data", 64'(samp_data), 64'(model_head()));
    checkOutput("frame_err", 64'(samp_fe), 64'(exp_fe));
    checkOutput("overflow", 64'(samp_ov), 64'(exp_ov));
    checkOutput("drop_cnt", 64'(samp_drop), 64'(sat_at(drop_m, 255)));
    checkOutput("drop_cnt_sat", 64'(sat_drop), 64'(sat_at(drop_m, 3)));
    S_data   = sd;
    RX_Ready = rdy;
    pop_m  = (model_q.size() != 0) && rdy;
    exp_fe = (ev == 2);
    exp_ov = (ev == 1) && (model_q.size() == DEPTH) && !pop_m;
    if (pop_m) void'(model_q.pop_front());
    if (ev == 1 && !exp_ov) model_q.push_back(cur_frame);
    if (exp_fe || exp_ov) drop_m++;
  endtask

  task automatic send_frame(input logic [PKT_W-1:0] data, input int bad_stop, input int bad_par,
                            input int rdy_mode, input int stop_rdy);
    int perr;
    cur_frame = data;
    perr = 0;
    applyStimulus(1'b1, pick(rdy_mode), 0);
    for (int i = PKT_W - 1; i >= 0; i--) applyStimulus(data[i], pick(rdy_mode), 0);
`ifdef SERIAL_RX_PARITY_EN
    perr = bad_par;
    applyStimulus((^data) ^ (bad_par != 0), pick(rdy_mode), 0);
`endif
    applyStimulus(bad_stop != 0, pick(stop_rdy), (bad_stop != 0 || perr != 0) ? 2 : 1);
  endtask

  task automatic do_reset();
    @(negedge Clk_S);
    Rst = 1'b1; S_data = 1'b0; RX_Ready = 1'b0;
    @(negedge Clk_S);
    checkOutput("rst_valid", 64'(RX_Data_Valid), 64'(0));
    checkOutput("rst_data", 64'(RX_Data), 64'(0));
    checkOutput("rst_frame_err", 64'(RX_Frame_Err), 64'(0));
    checkOutput("rst_overflow", 64'(RX_Overflow), 64'(0));
    checkOutput("rst_drop_cnt", 64'(RX_Drop_Cnt), 64'(0));
    Rst = 1'b0;
    model_q.delete();
    exp_fe = 1'b0; exp_ov = 1'b0; drop_m = 0;
  endtask

  initial begin
    Rst = 1'b1; S_data = 1'b0; RX_Ready = 1'b0;
    exp_fe = 1'b0; exp_ov = 1'b0; drop_m = 0; cur_frame = '0;

    tbl[0] = mk(55'd1, 0, 0, 0, 1, 55'd1, 0, 0, 0, 0);
    tbl[1] = mk(55'd2, 0, 0, 0, 1, 55'd1, 0, 0, 0, 0);
    tbl[2] = mk(55'd3, 0, 0, 0, 1, 55'd1, 0, 0, 0, 0);
    tbl[3] = mk(55'd4, 0, 0, 0, 1, 55'd1, 0, 0, 0, 0);
    tbl[4] = mk(55'd5, 0, 0, 1, 1, 55'd2, 0, 0, 0, 0);
    tbl[5] = mk(55'd6, 0, 0, 0, 1, 55'd2, 0, 1, 1, 1);
    tbl[6] = mk(55'd7, 1, 0, 0, 1, 55'd2, 1, 0, 2, 2);
`ifdef SERIAL_RX_PARITY_EN
    tbl[7] = mk(55'd8, 0, 1, 0, 1, 55'd2, 1, 0, 3, 3);
`else
    tbl[7] = mk(55'd8, 1, 0, 0, 1, 55'd2, 1, 0, 3, 3);
`endif
    tbl[8] = mk(55'd9, 1, 0, 0, 1, 55'd2, 1, 0, 4, 3);

    do_reset();

    // Reset in the middle of a frame, then a clean frame.
    applyStimulus(1'b1, 1'b0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(logic'($urandom_range(0, 1)), 1'b0, 0);
    do_reset();
    send_frame(55'h_A5A5A5A5A5A5A, 0, 0, 0, 0);
    checkOutput("latency_not_early", 64'(samp_valid), 64'(0));
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("after_rst_valid", 64'(samp_valid), 64'(1));
    checkOutput("after_rst_data", 64'(samp_data), 64'(55'h_A5A5A5A5A5A5A));

    // Four back-to-back frames buffered, then drained one per cycle.
    do_reset();
    for (int k = 0; k < 4; k++) send_frame(PKT_W'(k + 1), 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 0);
      checkOutput("b2b_valid", 64'(samp_valid), 64'(k < 4));
      checkOutput("b2b_head", 64'(samp_data), 64'((k < 4) ? k + 1 : 0));
    end

    // Bad stop bit with the line held high: no false start until it drops back to 0.
    do_reset();
    send_frame(55'h123, 1, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 0);
    checkOutput("ferr_pulse", 64'(samp_fe), 64'(1));
    checkOutput("ferr_drop", 64'(samp_drop), 64'(1));
    applyStimulus(1'b1, 1'b0, 0);
    checkOutput("ferr_single", 64'(samp_fe), 64'(0));
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0);
    send_frame(55'h456, 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("ferr_next_valid", 64'(samp_valid), 64'(1));
    checkOutput("ferr_next_data", 64'(samp_data), 64'(55'h456));

    // Table: fill, pop-while-full, overflow, framing/parity errors, counter saturation.
    do_reset();
    for (int r = 0; r < 9; r++) begin
      send_frame(tbl[r].data, tbl[r].bad_stop, tbl[r].bad_par, 0, tbl[r].stop_rdy);
      applyStimulus(1'b0, 1'b0, 0);
      checkOutput("tbl_valid", 64'(samp_valid), 64'(tbl[r].exp_valid));
      checkOutput("tbl_head", 64'(samp_data), 64'(tbl[r].exp_head));
      checkOutput("tbl_frame_err", 64'(samp_fe), 64'(tbl[r].exp_fe));
      checkOutput("tbl_overflow", 64'(samp_ov), 64'(tbl[r].exp_ov));
      checkOutput("tbl_drop", 64'(samp_drop), 64'(tbl[r].exp_drop));
      checkOutput("tbl_drop_sat", 64'(sat_drop), 64'(tbl[r].exp_sat));
    end
    drain_exp[0] = 55'd2; drain_exp[1] = 55'd3; drain_exp[2] = 55'd4;
    drain_exp[3] = 55'd5; drain_exp[4] = 55'd0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 0);
      checkOutput("drain_head", 64'(samp_data), 64'(drain_exp[k]));
    end

    // Randomized frames, errors, gaps and consumer readiness.
    do_reset();
    for (int f = 0; f < 40; f++) begin
      logic [PKT_W-1:0] d;
      int bs;
      int bp;
      int mode;
      int gap;
      d    = PKT_W'({$urandom, $urandom});
      bs   = ($urandom_range(0, 7) == 0) ? 1 : 0;
      bp   = 0;
`ifdef SERIAL_RX_PARITY_EN
      bp   = (bs == 0 && $urandom_range(0, 7) == 0) ? 1 : 0;
`endif
      mode = int'($urandom_range(0, 2));
      send_frame(d, bs, bp, mode, mode);
      gap  = (bs != 0) ? 1 : int'($urandom_range(0, 1));
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, pick(mode), 0);
    end
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
